// File: rtl/branch_pkg.sv
// Shared types for the branch resolve queue: one tracked branch entry.
package branch_pkg;
  localparam int PC_NBITS = 32;

  typedef struct packed {
    logic [PC_NBITS-1:0] pc;
    logic                pred;
  } br_entry_t;
endpackage

// File: rtl/branch_entry_fifo.sv
// DEPTH-entry circular buffer of predicted branches with synchronous clear.
// Head entry is presented combinationally so the resolve compare happens in-cycle.
module branch_entry_fifo
  import branch_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  logic      clear,
  input  br_entry_t wdata,
  output br_entry_t rdata,
  output logic      full,
  output logic      empty
);

  br_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[head_q];

  // Payload write; a cleared cycle discards the incoming entry.
  always_comb begin
    mem_d = mem_q;
    if (push && !clear) mem_d[tail_q] = wdata;
  end

  // Pointer/count next state; clear wins over push/pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // Payload flops carry no reset; validity lives entirely in the count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order branch tracker between fetch and the predictor: captures predicted
// branches, resolves the oldest, emits a registered predictor update, and
// squashes wrong-path entries on mispredict or flush.
module branch_resolve_queue
  import branch_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int CNT_NBITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enq_val,
  output logic                 enq_rdy,
  input  logic [PC_NBITS-1:0]  enq_pc,
  input  logic                 enq_pred,
  input  logic                 res_val,
  input  logic                 res_taken,
  input  logic                 flush,
  output logic                 upd_en,
  output logic                 upd_val,
  output logic [PC_NBITS-1:0]  upd_pc,
  output logic                 mispredict,
  output logic                 res_err,
  output logic [CNT_NBITS-1:0] n_branches,
  output logic [CNT_NBITS-1:0] n_mispred
);

  localparam logic [CNT_NBITS-1:0] CNT_MAX = '1;

  br_entry_t head_ent, enq_ent;
  logic      full, empty;
  logic      enq_fire, res_fire, mis_now, clear;

  logic                 upd_en_q, upd_en_d;
  logic                 upd_val_q, upd_val_d;
  logic [PC_NBITS-1:0]  upd_pc_q, upd_pc_d;
  logic                 mispredict_q, mispredict_d;
  logic                 res_err_q, res_err_d;
  logic [CNT_NBITS-1:0] n_branches_q, n_branches_d;
  logic [CNT_NBITS-1:0] n_mispred_q, n_mispred_d;

  // Full blocks enqueue even when a resolve frees a slot this cycle (no bypass).
  assign enq_rdy  = !full;
  assign enq_fire = enq_val && !full;
  assign res_fire = res_val && !empty;
  assign mis_now  = res_fire && (res_taken != head_ent.pred);
  // Everything behind a mispredicting branch is wrong-path.
  assign clear    = flush || mis_now;
  assign enq_ent  = '{pc: enq_pc, pred: enq_pred};

  branch_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (enq_fire),
    .pop   (res_fire),
    .clear (clear),
    .wdata (enq_ent),
    .rdata (head_ent),
    .full  (full),
    .empty (empty)
  );

  // Update stage, error flag and saturating statistics.
  always_comb begin
    upd_en_d     = res_fire;
    mispredict_d = mis_now;
    upd_val_d    = upd_val_q;
    upd_pc_d     = upd_pc_q;
    if (res_fire) begin
      upd_val_d = res_taken;
      upd_pc_d  = head_ent.pc;
    end
    res_err_d    = res_err_q || (res_val && empty);
    n_branches_d = n_branches_q;
    n_mispred_d  = n_mispred_q;
    if (res_fire && n_branches_q != CNT_MAX) n_branches_d = n_branches_q + CNT_NBITS'(1);
    if (mis_now && n_mispred_q != CNT_MAX)   n_mispred_d  = n_mispred_q + CNT_NBITS'(1);
  end

  // Registered outputs; reset drops any in-flight update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_en_q     <= 1'b0;
      upd_val_q    <= 1'b0;
      upd_pc_q     <= '0;
      mispredict_q <= 1'b0;
      res_err_q    <= 1'b0;
      n_branches_q <= '0;
      n_mispred_q  <= '0;
    end else begin
      upd_en_q     <= upd_en_d;
      upd_val_q    <= upd_val_d;
      upd_pc_q     <= upd_pc_d;
      mispredict_q <= mispredict_d;
      res_err_q    <= res_err_d;
      n_branches_q <= n_branches_d;
      n_mispred_q  <= n_mispred_d;
    end
  end

  assign upd_en     = upd_en_q;
  assign upd_val    = upd_val_q;
  assign upd_pc     = upd_pc_q;
  assign mispredict = mispredict_q;
  assign res_err    = res_err_q;
  assign n_branches = n_branches_q;
  assign n_mispred  = n_mispred_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_branch_resolve_queue;
  localparam int DEPTH = 8;
  localparam int CNTW  = 4;              // narrow counters so saturation is reachable
  localparam int CMAX  = (1 << CNTW) - 1;

  logic            clk = 1'b0, reset = 1'b0;
  logic            enq_val = 0, enq_pred = 0, res_val = 0, res_taken = 0, flush = 0;
  logic [31:0]     enq_pc = '0;
  logic            enq_rdy, upd_en, upd_val, mispredict, res_err;
  logic [31:0]     upd_pc;
  logic [CNTW-1:0] n_branches, n_mispred;

  branch_resolve_queue #(.DEPTH(DEPTH), .CNT_NBITS(CNTW)) dut (
    .clk(clk), .reset(reset),
    .enq_val(enq_val), .enq_rdy(enq_rdy), .enq_pc(enq_pc), .enq_pred(enq_pred),
    .res_val(res_val), .res_taken(res_taken), .flush(flush),
    .upd_en(upd_en), .upd_val(upd_val), .upd_pc(upd_pc), .mispredict(mispredict),
    .res_err(res_err), .n_branches(n_branches), .n_mispred(n_mispred)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [32:0] mq[$];        // {pc, pred}
  logic        m_en, m_val, m_mis, m_err;
  logic [31:0] m_pc;
  int          m_nb, m_nm;
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_en = 0; m_val = 0; m_mis = 0; m_err = 0; m_pc = '0; m_nb = 0; m_nm = 0;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".upd_en"},     32'(upd_en),     32'(m_en));
    chk({tag, ".upd_val"},    32'(upd_val),    32'(m_val));
    chk({tag, ".upd_pc"},     upd_pc,          m_pc);
    chk({tag, ".mispredict"}, 32'(mispredict), 32'(m_mis));
    chk({tag, ".res_err"},    32'(res_err),    32'(m_err));
    chk({tag, ".n_branches"}, 32'(n_branches), 32'(m_nb));
    chk({tag, ".n_mispred"},  32'(n_mispred),  32'(m_nm));
  endtask

  // One clock cycle: drive, check ready, advance model, check registered outputs.
  task automatic cyc(input string tag, input logic ev, input logic [31:0] pc, input logic pr,
                     input logic rv, input logic rt, input logic fl);
    logic        rdy, fire, mis;
    logic [32:0] e;
    enq_val = ev; enq_pc = pc; enq_pred = pr; res_val = rv; res_taken = rt; flush = fl;
    #1;
    rdy = (mq.size() < DEPTH);
    chk({tag, ".enq_rdy"}, 32'(enq_rdy), 32'(rdy));
    fire = rv && (mq.size() > 0);
    mis  = 1'b0;
    m_en = fire;
    if (fire) begin
      e     = mq.pop_front();
      m_val = rt;
      m_pc  = e[32:1];
      mis   = (rt != e[0]);
      if (m_nb < CMAX) m_nb++;
      if (mis && m_nm < CMAX) m_nm++;
    end else if (rv) begin
      m_err = 1'b1;
    end
    m_mis = mis;
    if (fl || mis) mq.delete();
    else if (ev && rdy) mq.push_back({pc, pr});
    @(posedge clk);
    #1;
    chk_outs(tag);
  endtask

  initial begin
    logic [32:0] hd;
    logic        rt, pr;
    model_reset();
    // 1: reset held three cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst.enq_rdy", 32'(enq_rdy), 32'd1);
    chk_outs("rst");
    reset = 1'b1;

    // 2: single correct prediction
    cyc("t2.enq", 1, 32'h100, 1, 0, 0, 0);
    cyc("t2.res", 0, 0, 0, 1, 1, 0);
    cyc("t2.idle", 0, 0, 0, 0, 0, 0);

    // 3: fill, refuse ninth, enq+resolve while full
    for (int i = 0; i < DEPTH; i++) cyc("t3.fill", 1, 32'h300 + 32'(4*i), 1, 0, 0, 0);
    cyc("t3.ninth", 1, 32'h3f0, 1, 0, 0, 0);
    cyc("t3.fullres", 1, 32'h3f4, 1, 1, 1, 0);
    chk("t3.count", 32'(mq.size()), 32'd7);
    cyc("t3.refill", 1, 32'h3f8, 1, 0, 0, 0);
    cyc("t3.flush", 0, 0, 0, 0, 0, 1);

    // 4: mispredict squashes younger entries; then resolve on empty
    cyc("t4.e0", 1, 32'h200, 0, 0, 0, 0);
    cyc("t4.e1", 1, 32'h204, 1, 0, 0, 0);
    cyc("t4.e2", 1, 32'h208, 1, 0, 0, 0);
    cyc("t4.mis", 0, 0, 0, 1, 1, 0);
    cyc("t4.empty", 0, 0, 0, 1, 0, 0);
    cyc("t4.idle", 0, 0, 0, 0, 0, 0);

    // 5: 20 pipelined enq/resolve pairs crossing the pointer wrap
    cyc("t5.first", 1, 32'h1000, 1, 0, 0, 0);
    for (int i = 1; i < 20; i++) cyc("t5.pair", 1, 32'h1000 + 32'(4*i), 1, 1, 1, 0);
    cyc("t5.last", 0, 0, 0, 1, 1, 0);

    // 6: flush with same-cycle resolve and enqueue
    cyc("t6.e0", 1, 32'h600, 1, 0, 0, 0);
    cyc("t6.e1", 1, 32'h604, 1, 0, 0, 0);
    cyc("t6.flush", 1, 32'h608, 0, 1, 1, 1);
    chk("t6.count", 32'(mq.size()), 32'd0);
    cyc("t6.after", 0, 0, 0, 1, 1, 0);

    // Random traffic, resolves mostly agree with the head's prediction
    for (int n = 0; n < 1500; n++) begin
      pr = 1'($urandom);
      rt = 1'($urandom);
      if (mq.size() > 0 && $urandom_range(0, 99) < 85) begin
        hd = mq[0];
        rt = hd[0];
      end
      cyc("rnd", ($urandom_range(0, 99) < 60), $urandom & 32'hffff_fffc, pr,
          ($urandom_range(0, 99) < 45), rt, ($urandom_range(0, 99) < 3));
    end

    // Reset mid-stream, asserted between edges with a resolve pending
    cyc("mr.e0", 1, 32'h700, 1, 0, 0, 0);
    cyc("mr.e1", 1, 32'h704, 0, 0, 0, 0);
    res_val = 1; res_taken = 1; enq_val = 1; enq_pc = 32'h708;
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("mr.async.enq_rdy", 32'(enq_rdy), 32'd1);
    chk_outs("mr.async");
    @(posedge clk);
    #1;
    chk_outs("mr.held");
    enq_val = 0; res_val = 0; res_taken = 0;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    cyc("mr.empty", 0, 0, 0, 1, 1, 0);
    cyc("mr.enq", 1, 32'h800, 1, 0, 0, 0);
    cyc("mr.res", 0, 0, 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
